// File: rtl/fptd_loader_pkg.sv
// Shared state encoding and default geometry for the LLR frame loader.
package fptd_loader_pkg;

    localparam int DEF_LANES  = 7;
    localparam int DEF_BITS   = 200;
    localparam int FRAME_BITS = DEF_LANES * DEF_BITS;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SHIFT,
        DECODE,
        REPORT
    } loader_state_e;

endpackage

// File: rtl/lane_shift_reg.sv
// Serial-in/parallel-out register for one LLR lane; shifts left so the
// first bit received ends at the MSB once BITS shifts have been done.
module lane_shift_reg
    import fptd_loader_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            i_en,
    input  logic            i_bit,
    output logic [BITS-1:0] o_data
);

    logic [BITS-1:0] r_data;

    // NOTE: the whole lane is cleared asynchronously so a reset mid-frame never leaves partial LLRs visible.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= {r_data[BITS-2:0], i_bit};
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/llr_frame_loader.sv
// LLR frame loader: capture a frame from the serial lanes, start the FPTD decoder,
// report completion. Define LLR_FRAME_COUNTER_EN to build the live FrameCount counter.
module llr_frame_loader
    import fptd_loader_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int BITS       = DEF_BITS,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 4096,
    parameter int TO_W       = 13,
    parameter int RPT_CYCLES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Go,
    input  logic                  Mode,
    input  logic [LANES-1:0]      In,
    input  logic                  DecReady,
    output logic                  Start2,
    output logic                  ShiftEn,
    output logic [LANES*BITS-1:0] LaneData,
    output logic                  DecStart,
    output logic                  TestReady,
    output logic                  TimeoutFlag,
    output logic [15:0]           FrameCount
);

    loader_state_e    r_state;
    loader_state_e    w_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_timeout_flag;
    logic             r_go_hold;
    logic             w_shift_last;
    logic             w_to_last;
    logic             w_report_last;

    // r_bit_cnt counts shifted bits in SHIFT and held cycles in REPORT.
    assign w_shift_last  = (r_bit_cnt == CNT_W'(BITS - 1));
    assign w_to_last     = (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_report_last = (r_state == REPORT) && (r_bit_cnt == CNT_W'(RPT_CYCLES - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        Start2    = 1'b0;
        ShiftEn   = 1'b0;
        DecStart  = 1'b0;
        TestReady = 1'b0;
        case (r_state)
            IDLE: begin
                if (Go && !r_go_hold) w_next = REQ;
            end
            REQ: begin
                Start2 = 1'b1;
                w_next = SHIFT;
            end
            SHIFT: begin
                ShiftEn = 1'b1;
                if (w_shift_last) w_next = DECODE;
            end
            DECODE: begin
                DecStart = (r_to_cnt == '0);
                if (DecReady || w_to_last) w_next = REPORT;
            end
            REPORT: begin
                TestReady = 1'b1;
                if (w_report_last) w_next = (Go && !Mode) ? REQ : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_bit_cnt      <= '0;
            r_to_cnt       <= '0;
            r_timeout_flag <= 1'b0;
            r_go_hold      <= 1'b0;
        end else begin
            case (r_state)
                REQ: r_bit_cnt <= '0;
                SHIFT: begin
                    r_to_cnt <= '0;
                    if (w_shift_last) begin
                        r_bit_cnt      <= '0;
                        r_timeout_flag <= 1'b0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                DECODE: begin
                    if (!DecReady) begin
                        if (w_to_last) r_timeout_flag <= 1'b1;
                        else           r_to_cnt       <= r_to_cnt + TO_W'(1);
                    end
                end
                REPORT: r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                default: ;
            endcase
            // After a single-frame run, Go must drop before IDLE will start again.
            if (!Go)                        r_go_hold <= 1'b0;
            else if (w_report_last && Mode) r_go_hold <= 1'b1;
        end
    end

    assign TimeoutFlag = r_timeout_flag;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_shift_reg #(.BITS(BITS)) u_lane (
            .Clock  (Clock),
            .Reset  (Reset),
            .i_en   (ShiftEn),
            .i_bit  (In[l]),
            .o_data (LaneData[l*BITS +: BITS])
        );
    end

`ifdef LLR_FRAME_COUNTER_EN
    logic [15:0] r_frame_cnt;
    logic        w_decode_done;

    assign w_decode_done = (r_state == DECODE) && (DecReady || w_to_last);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_frame_cnt <= '0;
        end else if (w_decode_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign FrameCount = r_frame_cnt;
`else
    assign FrameCount = 16'd0;
`endif

endmodule
